// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered ripple-carry adder port.
package full_adder_pkg;

    localparam int WIDTH_DEFAULT = 1;
    localparam int WIDTH_MAX     = 64;

    // Sum is sized for the widest legal instance; narrower instances use the low bits.
    typedef struct packed {
        logic [WIDTH_MAX-1:0] sum;
        logic                 carry;
        logic                 ovf;
        logic                 zero;
    } result_t;

    localparam result_t RESULT_RESET = '{sum: '0, carry: 1'b0, ovf: 1'b0, zero: 1'b1};

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell used as a link in the ripple-carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_port.sv
// WIDTH-bit ripple-carry adder with carry-in, registered sum/carry/overflow/zero
// and a one-cycle valid pipeline without backpressure.
module full_adder_port
    import full_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH:0]   cy;
    logic [WIDTH-1:0] sum_nxt;
    result_t          res_nxt;

    assign cy[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (cy[i]),
            .s    (sum_nxt[i]),
            .cout (cy[i+1])
        );
    end

    // Overflow compares the carry into and out of the MSB cell.
    always_comb begin
        res_nxt                  = RESULT_RESET;
        res_nxt.sum[WIDTH-1:0]   = sum_nxt;
        res_nxt.carry            = cy[WIDTH];
        res_nxt.ovf              = cy[WIDTH] ^ cy[WIDTH-1];
        res_nxt.zero             = (res_nxt.sum == '0);
    end

    // Result registers load only on accepted inputs, so idle-cycle X never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= RESULT_RESET.sum[WIDTH-1:0];
            carry     <= RESULT_RESET.carry;
            ovf       <= RESULT_RESET.ovf;
            zero      <= RESULT_RESET.zero;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= res_nxt.sum[WIDTH-1:0];
                carry <= res_nxt.carry;
                ovf   <= res_nxt.ovf;
                zero  <= res_nxt.zero;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_port.sv
// Self-checking bench: three adder widths driven in lockstep, scoreboard of expected results.
module tb_full_adder_port;

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } exp_t;

    localparam exp_t EXP_RESET = '{sum: 16'd0, carry: 1'b0, ovf: 1'b0, zero: 1'b1};

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        c;
    logic [0:0]  a1, b1, s1;
    logic [7:0]  a8, b8, s8;
    logic [15:0] a16, b16, s16;
    logic        cy1, o1, z1, v1;
    logic        cy8, o8, z8, v8;
    logic        cy16, o16, z16, v16;

    int total = 0;
    int bad   = 0;

    exp_t q1[$];
    exp_t q8[$];
    exp_t q16[$];
    exp_t last1, last8, last16;

    full_adder_port #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c), .in_valid(in_valid),
        .sum(s1), .carry(cy1), .ovf(o1), .zero(z1), .out_valid(v1)
    );

    full_adder_port #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c), .in_valid(in_valid),
        .sum(s8), .carry(cy8), .ovf(o8), .zero(z8), .out_valid(v8)
    );

    full_adder_port #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .c(c), .in_valid(in_valid),
        .sum(s16), .carry(cy16), .ovf(o16), .zero(z16), .out_valid(v16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(int w, logic [15:0] x, logic [15:0] y, logic ci);
        logic [16:0] m;
        logic [16:0] full;
        exp_t        r;
        m       = (17'd1 << w) - 17'd1;
        full    = ({1'b0, x} & m) + ({1'b0, y} & m) + {16'd0, ci};
        r.sum   = full[15:0] & m[15:0];
        r.carry = full[w];
        r.ovf   = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
        r.zero  = (r.sum == 16'd0);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp(string tag, logic ov, logic [15:0] s, logic cy, logic of, logic z,
                       logic exp_valid, exp_t e);
        chk({tag, ".out_valid"}, {31'd0, ov}, {31'd0, exp_valid});
        chk({tag, ".sum"},       {16'd0, s},  {16'd0, e.sum});
        chk({tag, ".carry"},     {31'd0, cy}, {31'd0, e.carry});
        chk({tag, ".ovf"},       {31'd0, of}, {31'd0, e.ovf});
        chk({tag, ".zero"},      {31'd0, z},  {31'd0, e.zero});
    endtask

    task automatic step(logic r, logic v, logic ci,
                        logic [15:0] xa1, logic [15:0] xb1,
                        logic [15:0] xa8, logic [15:0] xb8,
                        logic [15:0] xa16, logic [15:0] xb16);
        logic pushed;
        exp_t e1, e8, e16;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        c        = ci;
        a1       = xa1[0:0];
        b1       = xb1[0:0];
        a8       = xa8[7:0];
        b8       = xb8[7:0];
        a16      = xa16;
        b16      = xb16;
        pushed   = v && !r;
        if (pushed) begin
            q1.push_back(model(1, xa1, xb1, ci));
            q8.push_back(model(8, xa8, xb8, ci));
            q16.push_back(model(16, xa16, xb16, ci));
        end
        @(posedge clk);
        #1;
        if (r) begin
            last1  = EXP_RESET;
            last8  = EXP_RESET;
            last16 = EXP_RESET;
            q1.delete();
            q8.delete();
            q16.delete();
        end else if (pushed) begin
            last1  = q1.pop_front();
            last8  = q8.pop_front();
            last16 = q16.pop_front();
        end
        e1  = last1;
        e8  = last8;
        e16 = last16;
        cmp("w1",  v1,  {15'd0, s1}, cy1,  o1,  z1,  pushed, e1);
        cmp("w8",  v8,  {8'd0, s8},  cy8,  o8,  z8,  pushed, e8);
        cmp("w16", v16, s16,         cy16, o16, z16, pushed, e16);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        c        = 1'b0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        last1 = EXP_RESET; last8 = EXP_RESET; last16 = EXP_RESET;

        // reset with a valid input in the same cycle: input is discarded
        step(1, 1, 0, 16'd1, 16'd1, 16'd5, 16'd3, 16'd5, 16'd3);
        step(1, 1, 0, 16'd1, 16'd1, 16'd5, 16'd3, 16'd5, 16'd3);
        chk("rst.sum8_zero", {24'd0, s8}, 32'd0);
        chk("rst.zero8",     {31'd0, z8}, 32'd1);
        step(0, 0, 0, 16'd1, 16'd1, 16'd5, 16'd3, 16'd5, 16'd3);

        // back-to-back directed vectors
        step(0, 1, 0, 16'd0, 16'd0, 16'h007F, 16'h0001, 16'h7FFF, 16'h0001);
        chk("w8_7f.sum", {24'd0, s8}, 32'h80);
        chk("w8_7f.ovf", {31'd0, o8}, 32'd1);
        step(0, 1, 0, 16'd0, 16'd1, 16'h00FF, 16'h0001, 16'hFFFF, 16'h0001);
        chk("w8_ff.sum",   {24'd0, s8},  32'h00);
        chk("w8_ff.carry", {31'd0, cy8}, 32'd1);
        chk("w8_ff.zero",  {31'd0, z8},  32'd1);
        step(0, 1, 0, 16'd1, 16'd0, 16'h0080, 16'h0080, 16'h8000, 16'h8000);
        step(0, 1, 0, 16'd1, 16'd1, 16'h0000, 16'h0000, 16'h1234, 16'h4321);
        chk("w1_11.sum",   {31'd0, s1},  32'd0);
        chk("w1_11.carry", {31'd0, cy1}, 32'd1);
        step(0, 1, 1, 16'd1, 16'd1, 16'h00FF, 16'h00FF, 16'hFFFF, 16'hFFFF);
        chk("w1_111.sum",   {31'd0, s1},  32'd1);
        chk("w1_111.carry", {31'd0, cy1}, 32'd1);
        chk("w16_wrap.sum", {16'd0, s16}, 32'hFFFF);

        // idle gap with junk operands: outputs hold, out_valid low
        step(0, 0, 1'bx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 16'hxxxx);
        step(0, 0, 1, 16'd0, 16'd0, 16'h0055, 16'h00AA, 16'h5555, 16'hAAAA);

        // mid-stream reset, then restart
        step(0, 1, 0, 16'd1, 16'd0, 16'h0011, 16'h0022, 16'h1111, 16'h2222);
        step(1, 1, 1, 16'd1, 16'd1, 16'h0005, 16'h0003, 16'h0005, 16'h0003);
        step(0, 0, 0, 16'd0, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        step(0, 1, 0, 16'd0, 16'd1, 16'h0040, 16'h0040, 16'h4000, 16'h4000);

        // randomized stream, mostly back-to-back with occasional gaps
        for (int i = 0; i < 1000; i++) begin
            step(0, ($urandom_range(0, 9) != 0), 1'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder_port.md
FULL_ADDER_PORT -- requirements
Module: full_adder_port

Interface
REQ-001 Clocking and reset SHALL be fixed: one clock; reset is synchronous and active-high.
REQ-002 Parameter: WIDTH, 1, operand width in bits (legal range 1..64).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: c  input  1  carry-in.
REQ-008 Port: in_valid  input  1  operands and carry-in valid this cycle.
REQ-009 Port: sum  output  WIDTH  registered sum bits.
REQ-010 Port: carry  output  1  registered carry-out.
REQ-011 Port: ovf  output  1  registered signed-overflow flag.
REQ-012 Port: zero  output  1  registered flag, high when sum == 0.
REQ-013 Port: out_valid  output  1  sum, carry, ovf and zero valid this cycle.
REQ-014 Inputs a, b and c SHALL be driven only by the consumer; outputs SHALL be driven only by this block, so the port directions form a design-side/bench-side split.

Function
REQ-015 The full result SHALL be {carry, sum} = a + b + c, computed exactly at WIDTH+1 bits with no truncation of the carry.
REQ-016 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-017 The block SHALL register its results with 1-cycle latency: when in_valid=1 at rising edge N, the results SHALL appear at edge N with out_valid=1 after that edge.
REQ-018 When in_valid=0 at an edge, out_valid SHALL go to 0 and sum, carry, ovf and zero SHALL hold their previous values.
REQ-019 The handshake SHALL have no backpressure: every valid input cycle produces exactly one out_valid cycle, and back-to-back inputs SHALL produce back-to-back outputs.
REQ-020 Wrap-around: all-ones + all-ones + 1 SHALL give sum = all-ones and carry = 1.
REQ-021 The addition SHALL use a ripple chain of 1-bit full-adder cells, with sum_i = a_i ^ b_i ^ c_i and c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i, where c_0 = c.
REQ-022 X on inputs while in_valid=0 SHALL NOT propagate to the outputs.

Reset
REQ-023 While rst=1 at a rising edge, the block SHALL load sum=0, carry=0, ovf=0, zero=1 and out_valid=0.
REQ-024 Reset SHALL take priority over in_valid; an input presented in the same cycle as reset SHALL be discarded.
REQ-025 Deassertion of reset mid-stream SHALL NOT produce a spurious out_valid; the first output SHALL come 1 cycle after the first in_valid accepted out of reset.

Structure
REQ-026 A shared package full_adder_pkg SHALL hold the WIDTH default constant and a result struct typedef {sum, carry, ovf, zero}.
REQ-027 A single sub-module, full_adder_cell (1-bit: a, b, cin -> s, cout), SHALL be instantiated WIDTH times via a generate loop.
REQ-028 The block SHALL contain no latches and one always_ff process for the output registers.

Verification
REQ-029 With WIDTH=1 and c=0, {a,b} = 00, 01, 10, 11 applied on consecutive cycles with in_valid=1 SHALL produce sum/carry = 0/0, 1/0, 1/0, 0/1, one cycle later each.
REQ-030 With WIDTH=1, a=1, b=1, c=1 SHALL produce sum=1, carry=1.
REQ-031 With WIDTH=8, a=0x7F, b=0x01, c=0 SHALL produce sum=0x80, carry=0, ovf=1, zero=0.
REQ-032 With WIDTH=8, a=0xFF, b=0x01, c=0 SHALL produce sum=0x00, carry=1, ovf=0, zero=1.
REQ-033 With rst=1 together with in_valid=1 and a=5, b=3 SHALL produce out_valid=0, sum=0 and zero=1 next cycle; a later gap with in_valid=0 SHALL hold the outputs with out_valid=0.
REQ-034 Randomized back-to-back stream (1000 vectors, WIDTH=1 and 16) SHALL match a reference model of a+b+c exactly, with 1-cycle latency.
